// File: rtl/fp32_pkg.sv
// Shared FP32 definitions for the sequential divider.
// Holds the field layout, the exponent bias, the number of quotient bits the
// restoring divider produces, the controller state encoding and the
// special-operand classification in its priority order.
package fp32_pkg;

    localparam int SIGN_POS  = 31;
    localparam int EXP_W     = 8;
    localparam int MANT_W    = 23;
    localparam int BIAS      = 127;
    localparam logic [EXP_W-1:0] EXP_MAX = 8'hFF;

    // One integer bit, 23 fraction bits, guard bit and one extra bit for
    // the case where the quotient of the significands is below 1.0.
    localparam int QUOT_BITS = 26;
    localparam int CNT_W     = 5;

    typedef enum logic [1:0] {
        IDLE,
        DIVIDE,
        ROUND,
        DONE
    } state_t;

    // Special operand classes; the declaration order is the priority order.
    typedef enum logic [1:0] {
        SPC_NONE,
        SPC_EXCEPTION,
        SPC_DIV_ZERO,
        SPC_ZERO
    } special_t;

    // Operands with a zero exponent are flushed to zero, so only the
    // exponent fields decide the class.
    function automatic special_t classify(input logic [EXP_W-1:0] exp_a,
                                          input logic [EXP_W-1:0] exp_b);
        if (exp_a == EXP_MAX || exp_b == EXP_MAX) return SPC_EXCEPTION;
        if (exp_b == '0)                          return SPC_DIV_ZERO;
        if (exp_a == '0)                          return SPC_ZERO;
        return SPC_NONE;
    endfunction

endpackage

// File: rtl/fp32_mant_div_iter.sv
// Restoring division of two 24-bit significands, one quotient bit per clock.
// Ports:
//   clk    - clock
//   load   - capture op_a as the initial remainder and op_b as the divisor
//   step   - perform one restoring iteration
//   op_a   - dividend significand {1, fraction}
//   op_b   - divisor significand {1, fraction}
//   done   - the current step is the last of QUOT_BITS iterations
//   q      - quotient, MSB (weight 2^0) produced first
//   rem_nz - remainder is non-zero (feeds the sticky bit)
module fp32_mant_div_iter
    import fp32_pkg::*;
(
    input  logic                 clk,
    input  logic                 load,
    input  logic                 step,
    input  logic [MANT_W:0]      op_a,
    input  logic [MANT_W:0]      op_b,
    output logic                 done,
    output logic [QUOT_BITS-1:0] q,
    output logic                 rem_nz
);

    // After a subtraction the remainder is below the divisor (< 2^24), so the
    // shifted value always fits in 25 bits.
    localparam int REM_W = MANT_W + 2;
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(QUOT_BITS - 1);

    logic [REM_W-1:0]  rem;
    logic [MANT_W:0]   divisor;
    logic [CNT_W-1:0]  cnt;
    logic [REM_W-1:0]  div_ext;
    logic [REM_W-1:0]  rem_sub;
    logic              fits;

    always_comb begin
        div_ext = {1'b0, divisor};
        fits    = (rem >= div_ext);
        rem_sub = fits ? (rem - div_ext) : rem;
    end

    always_ff @(posedge clk) begin
        if (load) begin
            rem     <= {1'b0, op_a};
            divisor <= op_b;
            q       <= '0;
            cnt     <= '0;
        end else if (step) begin
            rem <= rem_sub << 1;
            q   <= {q[QUOT_BITS-2:0], fits};
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign done   = (cnt == LAST_STEP);
    assign rem_nz = |rem;

endmodule

// File: rtl/fp32_divider_seq.sv
// Sequential IEEE-754 single-precision divider, res = a / b.
// Denormal operands are flushed to zero; rounding is to nearest even.
// Ports:
//   clk, rst           - clock, synchronous active-high reset
//   in_valid, in_ready - operand handshake (in_ready high only when idle)
//   a, b               - dividend and divisor, FP32
//   out_valid, out_ready - result handshake; res/flags held until accepted
//   res                - quotient, FP32
//   exception          - an operand has exponent 8'hFF
//   div_by_zero        - divisor is zero and no exception
//   overflow/underflow - final biased exponent out of the normal range
module fp32_divider_seq
    import fp32_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] res,
    output logic        exception,
    output logic        div_by_zero,
    output logic        overflow,
    output logic        underflow
);

    localparam int EXP_CALC_W = EXP_W + 2;
    localparam logic signed [EXP_CALC_W-1:0] BIAS_S = EXP_CALC_W'(BIAS);

    typedef struct packed {
        logic [31:0] res;
        logic        ovf;
        logic        unf;
    } round_t;

    // Normalise the quotient, round to nearest even and pack the result,
    // saturating to infinity / flushing to zero outside the exponent range.
    function automatic round_t round_pack(input logic                 sign,
                                          input logic [EXP_W-1:0]     exp_a,
                                          input logic [EXP_W-1:0]     exp_b,
                                          input logic [QUOT_BITS-1:0] quo,
                                          input logic                 rem_nz);
        round_t                        r;
        logic [MANT_W-1:0]             mant;
        logic                          guard;
        logic                          sticky;
        logic                          adj;
        logic                          inc;
        logic [MANT_W:0]               sum;
        logic signed [EXP_CALC_W-1:0]  e;

        r = '0;
        if (quo[QUOT_BITS-1]) begin
            mant   = quo[QUOT_BITS-2:2];
            guard  = quo[1];
            sticky = quo[0] | rem_nz;
            adj    = 1'b0;
        end else begin
            mant   = quo[QUOT_BITS-3:1];
            guard  = quo[0];
            sticky = rem_nz;
            adj    = 1'b1;
        end
        inc = guard & (sticky | mant[0]);
        // A carry out leaves sum[MANT_W-1:0] at zero, which is the
        // correctly renormalised fraction.
        sum = {1'b0, mant} + {{MANT_W{1'b0}}, inc};
        e   = $signed({2'b00, exp_a}) - $signed({2'b00, exp_b}) + BIAS_S
              - $signed({{(EXP_CALC_W-1){1'b0}}, adj})
              + $signed({{(EXP_CALC_W-1){1'b0}}, sum[MANT_W]});

        if (e >= EXP_CALC_W'(255)) begin
            r.res = {sign, EXP_MAX, {MANT_W{1'b0}}};
            r.ovf = 1'b1;
        end else if (e <= EXP_CALC_W'(0)) begin
            r.res = {sign, {(EXP_W+MANT_W){1'b0}}};
            r.unf = 1'b1;
        end else begin
            r.res = {sign, e[EXP_W-1:0], sum[MANT_W-1:0]};
        end
        return r;
    endfunction

    state_t              state_q;
    state_t              state_d;
    special_t            spc;
    logic                accept;
    logic                load;
    logic                step;
    logic                done;
    logic                rem_nz;
    logic [QUOT_BITS-1:0] quo;
    logic                sign_in;
    logic [EXP_W-1:0]    exp_a_in;
    logic [EXP_W-1:0]    exp_b_in;
    logic [MANT_W:0]     op_a;
    logic [MANT_W:0]     op_b;
    logic                sign_q;
    logic [EXP_W-1:0]    exp_a_q;
    logic [EXP_W-1:0]    exp_b_q;
    round_t              rnd;

    assign sign_in  = a[SIGN_POS] ^ b[SIGN_POS];
    assign exp_a_in = a[SIGN_POS-1 -: EXP_W];
    assign exp_b_in = b[SIGN_POS-1 -: EXP_W];
    assign op_a     = {1'b1, a[MANT_W-1:0]};
    assign op_b     = {1'b1, b[MANT_W-1:0]};
    assign spc      = classify(exp_a_in, exp_b_in);
    assign rnd      = round_pack(sign_q, exp_a_q, exp_b_q, quo, rem_nz);

    fp32_mant_div_iter u_iter (
        .clk    (clk),
        .load   (load),
        .step   (step),
        .op_a   (op_a),
        .op_b   (op_b),
        .done   (done),
        .q      (quo),
        .rem_nz (rem_nz)
    );

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        accept    = 1'b0;
        load      = 1'b0;
        step      = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    accept  = 1'b1;
                    load    = (spc == SPC_NONE);
                    state_d = (spc == SPC_NONE) ? DIVIDE : DONE;
                end
            end
            DIVIDE: begin
                step = 1'b1;
                if (done) state_d = ROUND;
            end
            ROUND: state_d = DONE;
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Result and flags; res keeps its old value through a normal-path
    // division and is only rewritten once the rounded value is ready.
    always_ff @(posedge clk) begin
        if (rst) begin
            res         <= '0;
            exception   <= 1'b0;
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
            underflow   <= 1'b0;
        end else if (accept) begin
            sign_q      <= sign_in;
            exp_a_q     <= exp_a_in;
            exp_b_q     <= exp_b_in;
            exception   <= 1'b0;
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
            underflow   <= 1'b0;
            case (spc)
                SPC_EXCEPTION: begin
                    res       <= '0;
                    exception <= 1'b1;
                end
                SPC_DIV_ZERO: begin
                    res         <= {sign_in, EXP_MAX, {MANT_W{1'b0}}};
                    div_by_zero <= 1'b1;
                end
                SPC_ZERO: res <= {sign_in, {(EXP_W+MANT_W){1'b0}}};
                default: ;
            endcase
        end else if (state_q == ROUND) begin
            res       <= rnd.res;
            overflow  <= rnd.ovf;
            underflow <= rnd.unf;
        end
    end

endmodule

// File: doc/fp32_divider_seq.md
Name: fp32_divider_seq

Overview:
- Sequential IEEE-754 single-precision divider (res = a / b); the inverse-direction companion to the team's combinational FP32 multiplier.
- Same flag set (exception/overflow/underflow) and flush-to-zero policy, plus a div_by_zero flag.
- Mantissa quotient is computed by restoring division, one bit per clock, behind valid/ready handshakes on both sides.

Parameters:
- None. The format is fixed to FP32; field widths, BIAS=127 and iteration count live in the shared package.

Ports:
- clk  input  1  clock; all state updates on posedge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operands a/b presented.
- in_ready  output  1  divider idle, can accept.
- a  input  32  dividend, FP32.
- b  input  32  divisor, FP32.
- out_valid  output  1  res and flags valid.
- out_ready  input  1  consumer accepts result.
- res  output  32  quotient, FP32.
- exception  output  1  a or b exponent == 8'hFF.
- div_by_zero  output  1  b exponent == 0 and no exception.
- overflow  output  1  final biased exponent >= 255.
- underflow  output  1  final biased exponent <= 0.

Behaviour:
Interface and reset:
- One clock (clk); reset rst is synchronous and active-high. rst dominates every other input.
- Reset values: state=IDLE, in_ready=1, out_valid=0, res=0, all flags 0.
- Reset mid-operation aborts the division with no output, and the block is back in IDLE the next cycle.

FSM (IDLE, DIVIDE, ROUND, DONE):
- IDLE:
  - in_ready=1. Accept when in_valid&in_ready.
  - On accept, capture sign=a[31]^b[31] and the 8-bit exponents.
  - op_a={1,a[22:0]}, op_b={1,b[22:0]}.
  - Flush-to-zero: any operand with exponent 0 is zero.
  - Special priority on accept (go straight to DONE, no DIVIDE):
    - exception → res=0, exception=1.
    - b exp==0 → res={sign,8'hFF,23'd0}, div_by_zero=1.
    - a exp==0 → res={sign,31'd0}, no flags.
    - Otherwise go to DIVIDE.
- DIVIDE:
  - Runs exactly 26 cycles, driven by a 5-bit counter.
  - Remainder R is 25 bits and starts as op_a.
  - Each cycle: if R>=op_b then q bit=1, R=R-op_b; then R=R<<1.
  - Quotient bits fill q[25] down to q[0]; q[25] has weight 2^0.
- ROUND (1 cycle):
  - If q[25]=1: mant=q[24:2], guard=q[1], sticky=q[0]|(R!=0), adj=0.
  - Otherwise: mant=q[23:1], guard=q[0], sticky=(R!=0), adj=1.
  - Round to nearest even: increment when guard&(sticky|mant[0]). A carry out of mant sets mant=0 and adds 1 to the exponent.
  - Exponent is 10-bit signed: e = a_exp - b_exp + 127 - adj + carry.
  - e>=255 → res={sign,8'hFF,0}, overflow=1.
  - e<=0 → res={sign,31'd0}, underflow=1.
  - Otherwise res={sign,e[7:0],mant}.
- DONE:
  - out_valid=1. res and flags are held stable until out_ready=1.
  - On that cycle go to IDLE; out_valid drops the next cycle.
  - Flags are registered with res and cleared on the next accept.

Latency and throughput:
- Normal path: accept at cycle 0, out_valid high at cycle 28.
- Special path: out_valid high at cycle 1.
- One operation in flight; in_ready=0 outside IDLE.
- out_ready is ignored while out_valid=0.

Decomposition:
- Shared package fp32_pkg: FP32 field widths (SIGN_POS, EXP_W=8, MANT_W=23), BIAS=127, EXP_MAX=8'hFF, QUOT_BITS=26, the state enum {IDLE,DIVIDE,ROUND,DONE}, and flag-priority constants.
- Sub-module fp32_mant_div_iter: restoring-division datapath with R/q/counter registers and ports load, step, done, q, rem_nz.
- Top level holds the FSM, special-case decode, rounding and packing.

Test Plan:
- 40C00000/40000000 (6.0/2.0) → res=40400000, all flags 0, out_valid exactly 28 cycles after accept.
- 3F800000/40400000 (1/3) → res=3EAAAAAB (RNE increment); 7F000000/3F000000 → res=7F800000, overflow=1.
- 00800000/40000000 → e=0, res=00000000, underflow=1. Sign check: 00800000 as a with b=C0000000 → res=80000000, underflow=1.
- 3F800000/00000000 → res=7F800000, div_by_zero=1, out_valid 1 cycle after accept. 7F800000/3F800000 → res=0, exception=1 (exception wins over div_by_zero for 7F800000/00000000).
- Backpressure: hold out_ready=0 for 5 cycles in DONE → res/flags stable, in_ready=0. A new in_valid offered meanwhile is not accepted until 1 cycle after out_ready.
- Assert rst for 1 cycle at DIVIDE cycle 10 → next cycle IDLE, out_valid=0, res=0. A following 40C00000/40000000 still returns 40400000 at cycle 28.
